bp_me_io_load_arbiter: RTL and testbench

Round-robin arbiter that shares one I/O command/response channel (the host-link load port) among `num_req_p` nonsynth requesters, such as the NBF loader and the CCE MMIO config loader. It replaces fixed-priority muxing, so requesters may overlap in time. Every issued command is tagged with its requester index in an in-order tag FIFO, so each response returns to its originator. It sits between the loaders and `bp_me_cce_to_mem_link_bidir` in the top-level testbench.

---
 rtl/bp_me_io_load_arbiter.sv | 128 ++++++++++++
 tb/tb_bp_me_io_load_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_io_load_arbiter.sv
// Round-robin arbiter sharing one host-link I/O command/response channel among
// several loaders; an in-order tag FIFO steers each response back to its issuer.
module bp_me_io_load_arbiter #(
  // Processor config selector: 0 selects BP_CFG_FLOWVAR.
  parameter int bp_params_p          = 0,
  parameter int cce_mem_msg_width_lp = (bp_params_p == 0) ? 128 : 64,
  parameter int num_req_p            = 2,
  parameter int max_outstanding_p    = 4,
  localparam int msg_w = cce_mem_msg_width_lp,
  localparam int cnt_w = $clog2(max_outstanding_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p*msg_w-1:0]   req_cmd_i,
  input  logic [num_req_p-1:0]         req_cmd_v_i,
  output logic [num_req_p-1:0]         req_cmd_ready_o,
  output logic [msg_w-1:0]             req_resp_o,
  output logic [num_req_p-1:0]         req_resp_v_o,
  input  logic [num_req_p-1:0]         req_resp_ready_i,
  output logic [msg_w-1:0]             io_cmd_o,
  output logic                         io_cmd_v_o,
  input  logic                         io_cmd_ready_i,
  input  logic [msg_w-1:0]             io_resp_i,
  input  logic                         io_resp_v_i,
  output logic                         io_resp_yumi_o,
  output logic [cnt_w-1:0]             outstanding_o,
  output logic                         err_o
);

  localparam int idx_w = $clog2(num_req_p);
  localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  logic [idx_w-1:0] last_q, last_d;
  logic [idx_w-1:0] fifo_q [max_outstanding_p];
  logic [idx_w-1:0] fifo_d [max_outstanding_p];
  logic [ptr_w-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             credit_ok, rr_found, grant_v, push, pop, empty;
  logic [idx_w-1:0] rr_j, grant_idx, head;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(max_outstanding_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign credit_ok = (count_q != cnt_w'(max_outstanding_p));
  assign empty     = (count_q == '0);
  assign head      = fifo_q[rptr_q];

  // Search begins just after the last winner so every requester gets a turn.
  always_comb begin
    rr_found  = 1'b0;
    rr_j      = '0;
    grant_idx = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      rr_j = idx_w'((int'(last_q) + k) % num_req_p);
      if (!rr_found && req_cmd_v_i[rr_j]) begin
        rr_found  = 1'b1;
        grant_idx = rr_j;
      end
    end
  end

  assign grant_v    = rr_found & credit_ok;
  assign io_cmd_v_o = grant_v;
  assign push       = grant_v & io_cmd_ready_i;

  always_comb begin
    io_cmd_o        = '0;
    req_cmd_ready_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant_v && grant_idx == idx_w'(i)) begin
        io_cmd_o           = req_cmd_i[i*msg_w +: msg_w];
        req_cmd_ready_o[i] = io_cmd_ready_i;
      end
    end
  end

  // With no tag outstanding a response is swallowed rather than left to stall the link.
  always_comb begin
    req_resp_v_o   = '0;
    io_resp_yumi_o = io_resp_v_i;
    pop            = 1'b0;
    if (!empty) begin
      req_resp_v_o[head] = io_resp_v_i;
      io_resp_yumi_o     = io_resp_v_i & req_resp_ready_i[head];
      pop                = io_resp_v_i & req_resp_ready_i[head];
    end
  end

  assign req_resp_o    = io_resp_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

  always_comb begin
    last_d = push ? grant_idx : last_q;
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = grant_idx;
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (empty & io_resp_v_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q  <= idx_w'(num_req_p - 1);
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < max_outstanding_p; i++) fifo_q[i] <= '0;
    end else begin
      last_q  <= last_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule

// File: tb/tb_bp_me_io_load_arbiter.sv
// Scoreboard bench for bp_me_io_load_arbiter: issuer tags are queued on command
// fire and popped when the matching response is routed.
module tb_bp_me_io_load_arbiter;
  localparam int W  = 16;
  localparam int N  = 2;
  localparam int M  = 4;
  localparam int CW = $clog2(M + 1);

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] req_cmd_i;
  logic [N-1:0]   req_cmd_v_i;
  logic [N-1:0]   req_cmd_ready_o;
  logic [W-1:0]   req_resp_o;
  logic [N-1:0]   req_resp_v_o;
  logic [N-1:0]   req_resp_ready_i;
  logic [W-1:0]   io_cmd_o;
  logic           io_cmd_v_o;
  logic           io_cmd_ready_i;
  logic [W-1:0]   io_resp_i;
  logic           io_resp_v_i;
  logic           io_resp_yumi_o;
  logic [CW-1:0]  outstanding_o;
  logic           err_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int model_last;
  int eg, er;
  logic [N-1:0] ev;

  bp_me_io_load_arbiter #(
    .cce_mem_msg_width_lp(W), .num_req_p(N), .max_outstanding_p(M)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_ready_o(req_cmd_ready_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_ready_i(req_resp_ready_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] payload(input int i, input int t);
    return W'(32'h1000 * (i + 1) + t);
  endfunction

  task automatic set_payloads(input int t);
    for (int i = 0; i < N; i++) req_cmd_i[i*W +: W] = payload(i, t);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; req_cmd_v_i = '0; io_cmd_ready_i = 1'b1; io_resp_v_i = 1'b0;
    io_resp_i = '0; req_resp_ready_i = '1; set_payloads(0);
    #12;
    checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_o); end
    checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_v_idle got %0b want 0", io_cmd_v_o); end
    req_cmd_v_i = 2'b11;
    #1;
    checks++; if (req_cmd_ready_o !== 2'b01) begin errors++; $display("FAIL reset_first_prio got %b want 01", req_cmd_ready_o); end
    req_cmd_v_i = '0;
    reset_i = 1'b0;
    model_last = N - 1;
    next_cycle();
  endtask

  task automatic test_single();
    for (int k = 0; k < 3; k++) begin
      set_payloads(k); req_cmd_v_i = 2'b01;
      #1;
      checks++; if (io_cmd_v_o !== 1'b1 || io_cmd_o !== payload(0, k) || req_cmd_ready_o !== 2'b01) begin
        errors++; $display("FAIL single_cmd got v=%0b d=%h r=%b want v=1 d=%h r=01", io_cmd_v_o, io_cmd_o, req_cmd_ready_o, payload(0, k)); end
      exp_q.push_back(0); model_last = 0;
      next_cycle();
      checks++; if (outstanding_o !== CW'(k + 1)) begin errors++; $display("FAIL single_outstanding_up got %0d want %0d", outstanding_o, k + 1); end
    end
    req_cmd_v_i = '0;
    for (int k = 0; k < 3; k++) begin
      io_resp_v_i = 1'b1; io_resp_i = W'(16'hE000 + k);
      #1;
      er = exp_q.pop_front(); ev = N'(1) << er;
      checks++; if (req_resp_v_o !== ev || io_resp_yumi_o !== 1'b1 || req_resp_o !== W'(16'hE000 + k)) begin
        errors++; $display("FAIL single_resp got v=%b y=%0b d=%h want v=%b y=1 d=%h", req_resp_v_o, io_resp_yumi_o, req_resp_o, ev, W'(16'hE000 + k)); end
      next_cycle();
      checks++; if (outstanding_o !== CW'(2 - k)) begin errors++; $display("FAIL single_outstanding_down got %0d want %0d", outstanding_o, 2 - k); end
    end
    io_resp_v_i = 1'b0;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL single_err got %0b want 0", err_o); end
  endtask

  task automatic test_fairness();
    for (int c = 0; c < 8; c++) begin
      set_payloads(c + 10); req_cmd_v_i = 2'b11;
      io_resp_v_i = (exp_q.size() > 0); io_resp_i = W'(c);
      #1;
      eg = (model_last + 1) % N;
      checks++; if (io_cmd_o !== payload(eg, c + 10) || req_cmd_ready_o !== N'(N'(1) << eg)) begin
        errors++; $display("FAIL fair_grant got d=%h r=%b want d=%h idx=%0d", io_cmd_o, req_cmd_ready_o, payload(eg, c + 10), eg); end
      if (io_resp_v_i) begin
        er = exp_q.pop_front(); ev = N'(1) << er;
        checks++; if (req_resp_v_o !== ev || io_resp_yumi_o !== 1'b1) begin
          errors++; $display("FAIL fair_resp got v=%b y=%0b want v=%b y=1", req_resp_v_o, io_resp_yumi_o, ev); end
      end
      exp_q.push_back(eg); model_last = eg;
      next_cycle();
      checks++; if (outstanding_o !== CW'(exp_q.size())) begin errors++; $display("FAIL fair_outstanding got %0d want %0d", outstanding_o, exp_q.size()); end
    end
    req_cmd_v_i = '0;
    while (exp_q.size() > 0) begin
      io_resp_v_i = 1'b1;
      #1;
      er = exp_q.pop_front(); ev = N'(1) << er;
      checks++; if (req_resp_v_o !== ev) begin errors++; $display("FAIL fair_drain got %b want %b", req_resp_v_o, ev); end
      next_cycle();
    end
    io_resp_v_i = 1'b0;
    checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL fair_empty got %0d want 0", outstanding_o); end
  endtask

  task automatic test_full();
    req_cmd_v_i = 2'b11;
    for (int c = 0; c < M; c++) begin
      set_payloads(c + 30);
      #1;
      eg = (model_last + 1) % N;
      checks++; if (io_cmd_v_o !== 1'b1 || io_cmd_o !== payload(eg, c + 30)) begin
        errors++; $display("FAIL full_fill got v=%0b d=%h want v=1 d=%h", io_cmd_v_o, io_cmd_o, payload(eg, c + 30)); end
      exp_q.push_back(eg); model_last = eg;
      next_cycle();
    end
    checks++; if (outstanding_o !== CW'(M)) begin errors++; $display("FAIL full_count got %0d want %0d", outstanding_o, M); end
    #1;
    checks++; if (io_cmd_v_o !== 1'b0 || req_cmd_ready_o !== 2'b00) begin
      errors++; $display("FAIL full_block got v=%0b r=%b want v=0 r=00", io_cmd_v_o, req_cmd_ready_o); end
    io_resp_v_i = 1'b1;
    #1;
    er = exp_q.pop_front(); ev = N'(1) << er;
    checks++; if (io_resp_yumi_o !== 1'b1 || req_resp_v_o !== ev) begin
      errors++; $display("FAIL full_pop got y=%0b v=%b want y=1 v=%b", io_resp_yumi_o, req_resp_v_o, ev); end
    checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL full_same_cycle got %0b want 0", io_cmd_v_o); end
    next_cycle();
    io_resp_v_i = 1'b0; set_payloads(40);
    #1;
    eg = (model_last + 1) % N;
    checks++; if (io_cmd_v_o !== 1'b1 || io_cmd_o !== payload(eg, 40) || outstanding_o !== CW'(M - 1)) begin
      errors++; $display("FAIL full_reenable got v=%0b d=%h n=%0d want v=1 d=%h n=%0d", io_cmd_v_o, io_cmd_o, outstanding_o, payload(eg, 40), M - 1); end
    exp_q.push_back(eg); model_last = eg;
    next_cycle();
    req_cmd_v_i = '0;
    while (exp_q.size() > 0) begin
      io_resp_v_i = 1'b1;
      #1;
      er = exp_q.pop_front(); ev = N'(1) << er;
      checks++; if (req_resp_v_o !== ev) begin errors++; $display("FAIL full_drain got %b want %b", req_resp_v_o, ev); end
      next_cycle();
    end
    io_resp_v_i = 1'b0;
  endtask

  task automatic test_backpressure();
    req_cmd_v_i = 2'b10; set_payloads(50);
    #1;
    checks++; if (req_cmd_ready_o !== 2'b10) begin errors++; $display("FAIL bp_issue got %b want 10", req_cmd_ready_o); end
    exp_q.push_back(1); model_last = 1;
    next_cycle();
    req_cmd_v_i = '0; io_resp_v_i = 1'b1; req_resp_ready_i = 2'b01;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (io_resp_yumi_o !== 1'b0 || req_resp_v_o !== 2'b10) begin
        errors++; $display("FAIL bp_hold got y=%0b v=%b want y=0 v=10", io_resp_yumi_o, req_resp_v_o); end
      next_cycle();
      checks++; if (outstanding_o !== CW'(1)) begin errors++; $display("FAIL bp_count got %0d want 1", outstanding_o); end
    end
    req_resp_ready_i = 2'b11;
    #1;
    er = exp_q.pop_front(); ev = N'(1) << er;
    checks++; if (io_resp_yumi_o !== 1'b1 || req_resp_v_o !== ev) begin
      errors++; $display("FAIL bp_release got y=%0b v=%b want y=1 v=%b", io_resp_yumi_o, req_resp_v_o, ev); end
    next_cycle();
    io_resp_v_i = 1'b0;
    checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL bp_popped got %0d want 0", outstanding_o); end
  endtask

  task automatic test_spurious();
    io_resp_v_i = 1'b1;
    #1;
    checks++; if (io_resp_yumi_o !== 1'b1 || req_resp_v_o !== 2'b00 || err_o !== 1'b0) begin
      errors++; $display("FAIL spur_drop got y=%0b v=%b e=%0b want y=1 v=00 e=0", io_resp_yumi_o, req_resp_v_o, err_o); end
    next_cycle();
    io_resp_v_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err got %0b want 1", err_o); end
    next_cycle();
    checks++; if (err_o !== 1'b1 || outstanding_o !== '0) begin
      errors++; $display("FAIL spur_sticky got e=%0b n=%0d want e=1 n=0", err_o, outstanding_o); end
  endtask

  task automatic test_reset_mid();
    req_cmd_v_i = 2'b01;
    for (int c = 0; c < 2; c++) begin
      set_payloads(60 + c);
      exp_q.push_back(0); model_last = 0;
      next_cycle();
    end
    req_cmd_v_i = '0;
    checks++; if (outstanding_o !== CW'(2)) begin errors++; $display("FAIL mid_pre got %0d want 2", outstanding_o); end
    #2 reset_i = 1'b1;
    #1;
    checks++; if (outstanding_o !== '0 || err_o !== 1'b0) begin
      errors++; $display("FAIL mid_async got n=%0d e=%0b want n=0 e=0", outstanding_o, err_o); end
    #1 reset_i = 1'b0;
    exp_q.delete(); model_last = N - 1;
    req_cmd_v_i = 2'b11; io_cmd_ready_i = 1'b0; set_payloads(70); io_resp_v_i = 1'b1;
    #1;
    checks++; if (io_cmd_v_o !== 1'b1 || io_cmd_o !== payload(0, 70) || req_cmd_ready_o !== 2'b00) begin
      errors++; $display("FAIL mid_grant0 got v=%0b d=%h r=%b want v=1 d=%h r=00", io_cmd_v_o, io_cmd_o, req_cmd_ready_o, payload(0, 70)); end
    checks++; if (io_resp_yumi_o !== 1'b1 || req_resp_v_o !== 2'b00) begin
      errors++; $display("FAIL mid_stale got y=%0b v=%b want y=1 v=00", io_resp_yumi_o, req_resp_v_o); end
    next_cycle();
    io_resp_v_i = 1'b0; io_cmd_ready_i = 1'b1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mid_stale_err got %0b want 1", err_o); end
    #1;
    checks++; if (req_cmd_ready_o !== 2'b01) begin errors++; $display("FAIL mid_fire got %b want 01", req_cmd_ready_o); end
    exp_q.push_back(0); model_last = 0;
    next_cycle();
    req_cmd_v_i = '0;
    checks++; if (outstanding_o !== CW'(1)) begin errors++; $display("FAIL mid_post got %0d want 1", outstanding_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
